obi_copy_mgr: RTL and testbench
===============================

Name: obi_copy_mgr

Overview:
OBI manager (initiator) that copies a block of 32-bit words from a source address to a destination address over the croc manager OBI port.
It is the initiator-side counterpart to the user-domain OBI register subordinates. It is normally driven by an obi_reg instance: the command fields feed `start_i` and the address/length inputs, and status is read back.
It issues one read, then one write per word, with strictly one outstanding transaction at any time.

Parameters:
LenWidth, 16, width of word-count length and progress counter
AidValue, 0, constant OBI aid driven on every request

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
start_i  in  1  start pulse; sampled only in IDLE
src_addr_i  in  32  source byte address; bits [1:0] ignored
dst_addr_i  in  32  destination byte address; bits [1:0] ignored
len_i  in  LenWidth  number of words to copy
busy_o  out  1  high while not in IDLE
done_o  out  1  one-cycle pulse on completion or abort
err_o  out  1  sticky error flag; cleared by an accepted start
words_done_o  out  LenWidth  words fully written in the current/last copy
obi_req_o  out  mgr_obi_req_t  OBI A-channel request
obi_rsp_i  in  mgr_obi_rsp_t  OBI grant/response

Behaviour:
- Reset: one clock domain; reset is synchronous and active-low (`rst_ni` sampled on the rising edge of `clk_i`).
  - State goes to IDLE.
  - All outputs are 0: `req`, `busy_o`, `done_o`, `err_o`, `words_done_o`, and all `a` fields.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - `start_i`=1 captures `src` and `dst` with bits [1:0] forced to 0, captures `len`, clears `err_o` and `words_done_o`.
  - If `len_i`=0: pulse `done_o` in the next cycle, stay in IDLE, issue no OBI traffic.
  - Otherwise go to RD_REQ.
- RD_REQ:
  - `req`=1, `we`=0, `addr`=cur_src, `be`=4'hF, `wdata`=0, `aid`=AidValue.
  - On `gnt`=1, go to RD_WAIT.
- RD_WAIT:
  - `req`=0.
  - On `rvalid`: latch `rdata` into the data register.
  - If `r.err`=1: set `err_o`, pulse `done_o`, go to IDLE.
  - Otherwise go to WR_REQ.
- WR_REQ:
  - `req`=1, `we`=1, `addr`=cur_dst, `be`=4'hF, `wdata`=latched data.
  - On `gnt`, go to WR_WAIT.
- WR_WAIT:
  - On `rvalid` with `r.err`: set `err_o`, pulse `done_o`, go to IDLE; `words_done_o` is not incremented.
  - On `rvalid` without error: increment `words_done_o`, add 4 to cur_src and cur_dst.
  - If `words_done_o`+1 equals `len`: pulse `done_o`, go to IDLE. Otherwise go to RD_REQ.
- OBI rules:
  - While `req`=1 and `gnt`=0, all A-channel fields are held stable and `req` is never withdrawn.
  - `gnt` may arrive in the same cycle `req` rises.
  - `rvalid` arrives no earlier than the cycle after `gnt`; `rvalid` while in a *_REQ or IDLE state is ignored.
  - The response `rid` is not checked.
- Timing: with zero-wait `gnt` and 1-cycle `rvalid`, each word takes 4 cycles.
  - `start` is accepted at edge 0 and `req` is visible in cycle 1.
  - `done_o` is high in the cycle after the final write `rvalid`.
- `start_i` while `busy_o`=1 is ignored.
- `done_o` is high only in IDLE, in the cycle after the final `rvalid`.
- Address arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0x0000_0000 without an error.
- `len` up to 2^LenWidth-1 is supported; the counter never overflows.
- Reset mid-operation: the FSM returns to IDLE at the next edge and `req` drops. The OBI subordinate must be reset in the same cycle, so a pending `rvalid` is discarded.

Decomposition:
- croc_pkg: reuse mgr_obi_req_t, mgr_obi_rsp_t and MgrObiCfg; add a localparam for the default copy length width.
- State enum stays local to the module.
- No sub-module is natural: one FSM plus address, data and count registers, using `common_cells` FF macros with synchronous reset.

Test Plan:
- Basic copy: `src`=0x1000 containing {0xA, 0xB, 0xC}, `dst`=0x2000, `len`=3, zero-wait subordinate.
  → 3 reads then 3 writes, strictly alternating; `dst` holds {0xA, 0xB, 0xC}; `done_o` 1 cycle at cycle 13; `words_done_o`=3; `err_o`=0.
- Grant backpressure: `gnt` delayed 0–5 random cycles, 1000 words.
  → A-channel stable while ungranted; memory matches; never more than 1 outstanding request.
- Error abort: read response `err` on word 2 of `len`=4.
  → `err_o`=1, `done_o` pulse, `words_done_o`=1, no write issued for word 2, return to IDLE.
- Zero length and busy start: `len`=0 gives a `done_o` pulse 1 cycle later with no `req`; `start` during a copy is ignored, with addresses and length unchanged.
- Wrap and unaligned: `src`=0xFFFF_FFFE, `len`=2.
  → reads at 0xFFFF_FFFC then 0x0000_0000; writes aligned to `dst` & ~3.
- Reset mid-copy: `rst_ni`=0 for 1 cycle during WR_REQ.
  → next cycle `req`=0, `busy_o`=0, `words_done_o`=0, `err_o`=0; a new copy then succeeds.

Source files
------------

// File: rtl/obi_copy_mgr_pkg.sv
// Shared OBI manager-port types for the copy engine, plus copy-length defaults.
package obi_copy_mgr_pkg;

  localparam int unsigned MgrObiAddrWidth     = 32;
  localparam int unsigned MgrObiDataWidth     = 32;
  localparam int unsigned MgrObiIdWidth       = 1;
  localparam int unsigned CopyLenWidthDefault = 16;

  typedef struct packed {
    logic [MgrObiAddrWidth-1:0]   addr;
    logic                         we;
    logic [MgrObiDataWidth/8-1:0] be;
    logic [MgrObiDataWidth-1:0]   wdata;
    logic [MgrObiIdWidth-1:0]     aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [MgrObiDataWidth-1:0] rdata;
    logic [MgrObiIdWidth-1:0]   rid;
    logic                       err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

  function automatic logic [MgrObiAddrWidth-1:0] word_align(input logic [MgrObiAddrWidth-1:0] a);
    return {a[MgrObiAddrWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/obi_copy_mgr.sv
// OBI manager copying len_i 32-bit words from src to dst: one read then one write per word,
// never more than one transaction outstanding.
module obi_copy_mgr
  import obi_copy_mgr_pkg::*;
#(
  parameter int unsigned LenWidth = CopyLenWidthDefault,
  parameter int unsigned AidValue = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LenWidth-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [LenWidth-1:0] words_done_o,
  output mgr_obi_req_t        obi_req_o,
  input  mgr_obi_rsp_t        obi_rsp_i
);

  typedef enum logic [2:0] {
    Idle   = 3'd0,
    RdReq  = 3'd1,
    RdWait = 3'd2,
    WrReq  = 3'd3,
    WrWait = 3'd4
  } state_e;

  state_e              state_d, state_q;
  logic [31:0]         src_d, src_q;
  logic [31:0]         dst_d, dst_q;
  logic [31:0]         data_d, data_q;
  logic [LenWidth-1:0] len_d, len_q;
  logic [LenWidth-1:0] cnt_d, cnt_q;
  logic                err_d, err_q;
  logic                done_d, done_q;
  logic [LenWidth-1:0] cnt_inc;

  // Response ID is not checked; only one transaction is ever in flight.
  logic unused_rid;
  assign unused_rid = ^obi_rsp_i.r.rid;

  assign cnt_inc = cnt_q + LenWidth'(1);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    obi_req_o = '0;

    unique case (state_q)
      Idle: begin
        if (start_i) begin
          src_d = word_align(src_addr_i);
          dst_d = word_align(dst_addr_i);
          len_d = len_i;
          err_d = 1'b0;
          cnt_d = '0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RdReq;
          end
        end
      end
      RdReq: begin
        obi_req_o.req     = 1'b1;
        obi_req_o.a.we    = 1'b0;
        obi_req_o.a.addr  = src_q;
        obi_req_o.a.be    = '1;
        obi_req_o.a.aid   = MgrObiIdWidth'(AidValue);
        if (obi_rsp_i.gnt) state_d = RdWait;
      end
      RdWait: begin
        if (obi_rsp_i.rvalid) begin
          data_d = obi_rsp_i.r.rdata;
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = Idle;
          end else begin
            state_d = WrReq;
          end
        end
      end
      WrReq: begin
        obi_req_o.req     = 1'b1;
        obi_req_o.a.we    = 1'b1;
        obi_req_o.a.addr  = dst_q;
        obi_req_o.a.be    = '1;
        obi_req_o.a.wdata = data_q;
        obi_req_o.a.aid   = MgrObiIdWidth'(AidValue);
        if (obi_rsp_i.gnt) state_d = WrWait;
      end
      WrWait: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = Idle;
          end else begin
            cnt_d = cnt_inc;
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            // cnt_q < len_q here, so cnt_inc cannot overflow.
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              state_d = Idle;
            end else begin
              state_d = RdReq;
            end
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Idle;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy_o       = (state_q != Idle);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = cnt_q;

endmodule

// File: tb/tb_obi_copy_mgr.sv
// Directed + randomized bench for obi_copy_mgr with a behavioural OBI memory subordinate.
module tb_obi_copy_mgr;
  import obi_copy_mgr_pkg::*;

  localparam int unsigned LW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src   = '0;
  logic [31:0]   dst   = '0;
  logic [LW-1:0] len   = '0;
  logic          busy, done, err;
  logic [LW-1:0] wdone;
  mgr_obi_req_t  req;
  mgr_obi_rsp_t  rsp = '0;

  int tests = 0;
  int fails = 0;

  obi_copy_mgr #(.LenWidth(LW), .AidValue(0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .src_addr_i  (src),
    .dst_addr_i  (dst),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .words_done_o(wdone),
    .obi_req_o   (req),
    .obi_rsp_i   (rsp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t         ops[$];
  op_t         exp_ops[$];
  logic [31:0] mem [logic [29:0]];

  int unsigned max_gnt    = 0;
  int unsigned max_rlat   = 0;
  int          err_rd_idx = -1;
  int          rd_cnt     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory subordinate: all response signals change on the falling edge only.
  logic            last_req = 1'b0;
  logic            last_gnt = 1'b0;
  logic            last_rst = 1'b0;
  mgr_obi_a_chan_t last_a   = '0;
  logic            pend_v   = 1'b0;
  int unsigned     pend_dly = 0;
  logic [31:0]     pend_data = '0;
  logic            pend_err = 1'b0;
  int unsigned     gnt_wait = 0;

  always @(negedge clk) begin
    logic [31:0] rd;
    if (last_rst && last_req && last_gnt) begin
      check("one_outstanding", 64'(pend_v), 64'd0);
      if (last_a.we) begin
        mem[last_a.addr[31:2]] = last_a.wdata;
        ops.push_back('{1'b1, last_a.addr, last_a.wdata});
        pend_data = '0;
        pend_err  = 1'b0;
      end else begin
        rd = mem.exists(last_a.addr[31:2]) ? mem[last_a.addr[31:2]] : 32'd0;
        ops.push_back('{1'b0, last_a.addr, rd});
        pend_data = rd;
        pend_err  = (rd_cnt == err_rd_idx);
        rd_cnt++;
      end
      pend_v   = 1'b1;
      pend_dly = $urandom_range(max_rlat, 0);
    end
    rsp = '0;
    if (!rst_n) begin
      pend_v = 1'b0;
    end else if (pend_v) begin
      if (pend_dly == 0) begin
        rsp.rvalid  = 1'b1;
        rsp.r.rdata = pend_data;
        rsp.r.err   = pend_err;
        pend_v      = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    if (rst_n && last_rst && last_req && !last_gnt) begin
      check("req_held", 64'(req.req), 64'd1);
      check("a_stable", 64'(req.a === last_a), 64'd1);
    end
    if (rst_n && req.req) begin
      if (!(last_rst && last_req && !last_gnt)) gnt_wait = $urandom_range(max_gnt, 0);
      if (gnt_wait == 0) rsp.gnt = 1'b1;
      else gnt_wait--;
    end
    last_req = req.req;
    last_gnt = rsp.gnt;
    last_a   = req.a;
    last_rst = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word i is read from src+4i and written to dst+4i; an erroring read ends the copy.
  task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int n, input int eidx);
    logic [31:0] sa, da, w;
    exp_ops.delete();
    sa = s & ~32'd3;
    da = d & ~32'd3;
    for (int i = 0; i < n; i++) begin
      w = mem.exists(sa[31:2]) ? mem[sa[31:2]] : 32'd0;
      exp_ops.push_back('{1'b0, sa, w});
      if (i == eidx) break;
      exp_ops.push_back('{1'b1, da, w});
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
  endtask

  task automatic check_ops(input string tag);
    int bad;
    bad = 0;
    check({tag, "_ops_count"}, 64'(ops.size()), 64'(exp_ops.size()));
    for (int i = 0; i < ops.size() && i < exp_ops.size(); i++)
      if (ops[i] !== exp_ops[i]) bad++;
    check({tag, "_ops_seq"}, 64'(bad), 64'd0);
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n);
    ops.delete();
    rd_cnt = 0;
    src = s; dst = d; len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    cyc = 1;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  initial begin
    int          cyc;
    int          found;
    logic [31:0] w0, w1;

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_req", 64'(req.req), 64'd0);
    check("rst_a", 64'(req.a === '0), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wdone", 64'(wdone), 64'd0);

    // Basic copy, zero-wait subordinate
    mem[30'h1000 >> 2] = 32'hA;
    mem[30'h1004 >> 2] = 32'hB;
    mem[30'h1008 >> 2] = 32'hC;
    build_exp(32'h1000, 32'h2000, 3, -1);
    start_copy(32'h1000, 32'h2000, 3);
    check("basic_req_cycle1", 64'(req.req), 64'd1);
    check("basic_aid", 64'(req.a.aid), 64'd0);
    check("basic_be", 64'(req.a.be), 64'hF);
    wait_done("basic", 100, cyc);
    check("basic_done_cycle", 64'(cyc), 64'd13);
    check("basic_wdone", 64'(wdone), 64'd3);
    check("basic_err", 64'(err), 64'd0);
    check_ops("basic");
    tick();
    check("basic_done_pulse", 64'(done), 64'd0);
    check("basic_idle", 64'(busy), 64'd0);

    // Grant/response backpressure over 1000 random words
    for (int i = 0; i < 1000; i++) mem[30'((32'h10000 >> 2) + i)] = $urandom();
    max_gnt = 5; max_rlat = 3;
    build_exp(32'h10000, 32'h40000, 1000, -1);
    start_copy(32'h10000, 32'h40000, 1000);
    wait_done("bp", 30000, cyc);
    check("bp_wdone", 64'(wdone), 64'd1000);
    check("bp_err", 64'(err), 64'd0);
    check_ops("bp");
    found = 0;
    for (int i = 0; i < 1000; i++)
      if (mem[30'((32'h40000 >> 2) + i)] !== mem[30'((32'h10000 >> 2) + i)]) found++;
    check("bp_mem", 64'(found), 64'd0);
    max_gnt = 0; max_rlat = 0;
    tick();

    // Read error on word 2 of 4
    for (int i = 0; i < 4; i++) mem[30'((32'h5000 >> 2) + i)] = $urandom();
    err_rd_idx = 1;
    build_exp(32'h5000, 32'h5800, 4, 1);
    start_copy(32'h5000, 32'h5800, 4);
    wait_done("err", 100, cyc);
    check("err_flag", 64'(err), 64'd1);
    check("err_wdone", 64'(wdone), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    err_rd_idx = -1;
    check_ops("err");
    check("err_sticky", 64'(err), 64'd1);

    // Zero length: done next cycle, no traffic, error cleared
    start_copy(32'h100, 32'h200, 0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_req", 64'(req.req), 64'd0);
    check("zero_err_cleared", 64'(err), 64'd0);
    tick();
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_no_ops", 64'(ops.size()), 64'd0);

    // Start while busy is ignored
    for (int i = 0; i < 2; i++) mem[30'((32'h6000 >> 2) + i)] = $urandom();
    build_exp(32'h6000, 32'h7000, 2, -1);
    start_copy(32'h6000, 32'h7000, 2);
    tick(); tick();
    src = 32'h8000; dst = 32'h9000; len = 7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy", 100, cyc);
    check("busy_wdone", 64'(wdone), 64'd2);
    check_ops("busy");
    tick();

    // Address wrap with unaligned inputs
    w0 = $urandom(); w1 = $urandom();
    mem[30'h3FFF_FFFF] = w0;
    mem[30'h0]         = w1;
    build_exp(32'hFFFF_FFFE, 32'h3003, 2, -1);
    start_copy(32'hFFFF_FFFE, 32'h3003, 2);
    wait_done("wrap", 100, cyc);
    check("wrap_wdone", 64'(wdone), 64'd2);
    check("wrap_err", 64'(err), 64'd0);
    check_ops("wrap");
    check("wrap_mem0", 64'(mem[30'h3000 >> 2]), 64'(w0));
    check("wrap_mem1", 64'(mem[30'h3004 >> 2]), 64'(w1));
    tick();

    // Reset during the second word's write request
    for (int i = 0; i < 3; i++) mem[30'((32'hA000 >> 2) + i)] = $urandom();
    start_copy(32'hA000, 32'hB000, 3);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (req.req && req.a.we && wdone == 1) found = 1;
      else tick();
    end
    check("mid_wr_req_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_req", 64'(req.req), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_wdone", 64'(wdone), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    tick();
    build_exp(32'hA000, 32'hC000, 3, -1);
    start_copy(32'hA000, 32'hC000, 3);
    wait_done("post_rst", 100, cyc);
    check("post_rst_wdone", 64'(wdone), 64'd3);
    check("post_rst_err", 64'(err), 64'd0);
    check_ops("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
